// File: rtl/packet_rx_pkg.sv
// Shared types and defaults for the packet_rx serial receiver.
package packet_rx_pkg;

    localparam int PKT_BITS_DEF   = 18;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } packet_rx_state_t;

    // Odd convention: a good packet has an odd number of ones.
    function automatic logic odd_parity_ok(input logic [17:0] pkt);
        return ^pkt;
    endfunction

endpackage

// File: rtl/packet_rx_bit_sampler.sv
// Input synchronizer, mid-bit sample counter and sample decision for packet_rx.
// Optional build macro: PACKET_RX_MAJORITY_EN (2-of-3 vote around mid-bit).
module rx_bit_sampler #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_rx,
    input  logic i_cnt_clr,
    output logic o_sync_bit,
    output logic o_sample_strobe,
    output logic o_sample_val
);

    localparam int CW = $clog2(OVERSAMPLE);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    // Counter is power-of-2 sized so it wraps once per bit without a compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sync_bit      = r_sync[1];
    assign o_sample_strobe = (r_cnt == CW'(OVERSAMPLE / 2 - 1));

`ifdef PACKET_RX_MAJORITY_EN
    logic r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= r_sync[1];
        end
    end

    // Third vote is taken from the first sync stage, i.e. the value the
    // synchronized bit will carry next clk, so the decision cycle is unchanged.
    assign o_sample_val = (r_prev & r_sync[1]) | (r_prev & r_sync[0]) |
                          (r_sync[1] & r_sync[0]);
`else
    assign o_sample_val = r_sync[1];
`endif

endmodule

// File: rtl/packet_rx.sv
// Oversampled serial packet receiver with parity/framing/overrun status.
// Optional build macro: PACKET_RX_MAJORITY_EN (majority-voted bit samples).
module packet_rx
    import packet_rx_pkg::*;
#(
    parameter int PKT_BITS   = PKT_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rx_in,
    input  logic                uld_rx_data,
    output logic [PKT_BITS-1:0] rx_data,
    output logic                rx_empty,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun
);

    localparam int BW = $clog2(PKT_BITS + 1);

    packet_rx_state_t    r_state;
    packet_rx_state_t    w_next;
    logic [BW-1:0]       r_bit;
    logic [PKT_BITS-1:0] r_shift;
    logic [PKT_BITS-1:0] r_data;
    logic                r_empty;
    logic                r_perr;
    logic                r_ferr;
    logic                r_ovr;

    logic w_sync_bit;
    logic w_strobe;
    logic w_sval;
    logic w_cnt_clr;
    logic w_last_bit;
    logic w_load;
    logic w_stop_bad;
    logic w_par_ok;

    assign w_cnt_clr = (r_state == IDLE) || (r_state == WAIT_HIGH);

    rx_bit_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_rx            (rx_in),
        .i_cnt_clr       (w_cnt_clr),
        .o_sync_bit      (w_sync_bit),
        .o_sample_strobe (w_strobe),
        .o_sample_val    (w_sval)
    );

    assign w_last_bit = (r_bit == BW'(PKT_BITS - 1));
    assign w_load     = (r_state == STOP) && w_strobe && w_sval;
    assign w_stop_bad = (r_state == STOP) && w_strobe && !w_sval;

    generate
        if (PKT_BITS == PKT_BITS_DEF) begin : g_par_def
            assign w_par_ok = odd_parity_ok(r_shift);
        end else begin : g_par_gen
            assign w_par_ok = ^r_shift;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (!w_sync_bit) w_next = START;
            START:     if (w_strobe) w_next = w_sval ? IDLE : DATA;
            DATA:      if (w_strobe && w_last_bit) w_next = STOP;
            STOP:      if (w_strobe) w_next = w_sval ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (w_sync_bit) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Shift right so the first bit received ends up in bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == START && w_strobe) begin
                r_bit <= '0;
            end
            if (r_state == DATA && w_strobe) begin
                r_shift <= {w_sval, r_shift[PKT_BITS-1:1]};
                r_bit   <= r_bit + 1'b1;
            end
            if (w_stop_bad) begin
                r_shift <= '0;
            end
        end
    end

    // Ordering matters: unload clears first, a same-cycle load then wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_empty <= 1'b1;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (uld_rx_data) begin
                r_empty <= 1'b1;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
                r_ovr   <= 1'b0;
            end
            if (w_load) begin
                if (r_empty || uld_rx_data) begin
                    r_data  <= r_shift;
                    r_empty <= 1'b0;
                    r_perr  <= ~w_par_ok;
                end else begin
                    r_ovr   <= 1'b1;
                end
            end
            if (w_stop_bad) begin
                r_ferr <= 1'b1;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_empty   = r_empty;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_packet_rx.sv
// Directed self-checking bench for packet_rx (default 18-bit packets, 16x oversampling).
module tb_packet_rx;
    import packet_rx_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_in;
    logic        uld_rx_data;
    logic [17:0] rx_data;
    logic        rx_empty;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    packet_rx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_in       (rx_in),
        .uld_rx_data (uld_rx_data),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One bit time, starting and ending on a negedge. The decision edge is the
    // 11th posedge after the drive (2 sync + OVERSAMPLE/2 + 1).
    task automatic bit_period(input logic val, input bit glitch, input bit uld_p, input bit lat);
        rx_in = val;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 8 && glitch) rx_in = ~val;
            if (k == 9) rx_in = val;
            if (k == 10) begin
                if (lat) chk("lat_before", 32'(rx_empty), 32'd1);
                if (uld_p) uld_rx_data = 1'b1;
            end
            if (k == 11) begin
                uld_rx_data = 1'b0;
                if (lat) chk("lat_after", 32'(rx_empty), 32'd0);
            end
        end
    endtask

    task automatic send_frame(input logic [17:0] pkt, input logic stop, input int glitch_bit,
                              input bit uld_at_stop, input bit lat);
        bit_period(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) bit_period(pkt[i], (i == glitch_bit), 1'b0, 1'b0);
        bit_period(stop, 1'b0, uld_at_stop, lat);
    endtask

    task automatic uld_pulse;
        uld_rx_data = 1'b1;
        @(negedge clk);
        uld_rx_data = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [17:0] d, input logic e,
                           input logic pe, input logic fe, input logic ov);
        chk({tag, "_data"}, 32'(rx_data), 32'(d));
        chk({tag, "_empty"}, 32'(rx_empty), 32'(e));
        chk({tag, "_perr"}, 32'(parity_err), 32'(pe));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(fe));
        chk({tag, "_ovr"}, 32'(overrun), 32'(ov));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_in       = 1'b1;
        uld_rx_data = 1'b0;
        reset_n     = 1'b0;
        repeat (3) @(negedge clk);
        chk_out("reset", 18'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: good frame (0x05A5B has 9 ones -> odd parity good), latency check
        send_frame(18'h05A5B, 1'b1, -1, 1'b0, 1'b1);
        chk_out("t1", 18'h05A5B, 1'b0, 1'b0, 1'b0, 1'b0);
        uld_pulse();
        chk("t1_uld_empty", 32'(rx_empty), 32'd1);
        chk("t1_uld_data", 32'(rx_data), 32'h05A5B);

        // 2: bit 17 inverted -> 10 ones, parity error
        send_frame(18'h25A5B, 1'b1, -1, 1'b0, 1'b0);
        chk_out("t2", 18'h25A5B, 1'b0, 1'b1, 1'b0, 1'b0);
        uld_pulse();
        chk("t2_uld_perr", 32'(parity_err), 32'd0);

        // 3: bad stop bit, line stuck low
        send_frame(18'h05A5B, 1'b0, -1, 1'b0, 1'b0);
        chk("t3_ferr", 32'(frame_err), 32'd1);
        chk("t3_empty", 32'(rx_empty), 32'd1);
        repeat (100) @(negedge clk);
        chk("t3_stuck_state", 32'(dut.r_state), 32'(WAIT_HIGH));
        chk("t3_stuck_empty", 32'(rx_empty), 32'd1);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        chk("t3_idle", 32'(dut.r_state), 32'(IDLE));
        send_frame(18'h00001, 1'b1, -1, 1'b0, 1'b0);
        chk_out("t3_good", 18'h00001, 1'b0, 1'b0, 1'b1, 1'b0);
        uld_pulse();
        chk("t3_uld_ferr", 32'(frame_err), 32'd0);

        // 4: overrun, then unload coincident with a load
        send_frame(18'h00007, 1'b1, -1, 1'b0, 1'b0);
        send_frame(18'h3FFFE, 1'b1, -1, 1'b0, 1'b0);
        chk_out("t4_ovr", 18'h00007, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(18'h1FFFF, 1'b1, -1, 1'b1, 1'b0);
        chk_out("t4_coinc", 18'h1FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        uld_pulse();

        // 5: short low pulse on idle line
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        chk_out("t5_glitch", 18'h1FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_state", 32'(dut.r_state), 32'(IDLE));
`ifdef PACKET_RX_MAJORITY_EN
        send_frame(18'h05A5B, 1'b1, 4, 1'b0, 1'b0);
        chk_out("t5_maj", 18'h05A5B, 1'b0, 1'b0, 1'b0, 1'b0);
        uld_pulse();
`endif

        // 6: reset in the middle of bit 9
        send_frame(18'h00003, 1'b1, -1, 1'b0, 1'b0);
        chk_out("t6_pre", 18'h00003, 1'b0, 1'b1, 1'b0, 1'b0);
        bit_period(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) bit_period(1'b1, 1'b0, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_out("t6_rst", 18'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_state", 32'(dut.r_state), 32'(IDLE));
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(18'h3FFFE, 1'b1, -1, 1'b0, 1'b0);
        chk_out("t6_good", 18'h3FFFE, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
